inst_prefetch_queue: RTL and testbench

//   Byte-wide instruction prefetch buffer between the memory bus and prime_decoder.

---
 rtl/inst_prefetch_queue_if.sv | 31 +++
 rtl/inst_prefetch_queue.sv | 137 +++++++++++++
 tb/tb_inst_prefetch_queue.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/inst_prefetch_queue_if.sv
// Bus/decoder bundle for the instruction prefetch queue.
// The master modport is the prefetch queue; the slave side is memory plus decoder.
interface inst_prefetch_queue_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 5
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              consume;
    logic [1:0]        consume_len;
    logic [CNT_W-1:0]  q_count;
    logic [7:0]        q_byte0;
    logic [7:0]        q_byte1;
    logic [7:0]        q_byte2;
    logic [ADDR_W-1:0] q_pc;
    logic              protocol_err;

    modport master (
        output mem_req, mem_addr, q_count, q_byte0, q_byte1, q_byte2, q_pc, protocol_err,
        input  mem_ack, mem_rdata, redirect, redirect_pc, consume, consume_len
    );

    modport slave (
        input  mem_req, mem_addr, q_count, q_byte0, q_byte1, q_byte2, q_pc, protocol_err,
        output mem_ack, mem_rdata, redirect, redirect_pc, consume, consume_len
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Byte-wide instruction prefetch queue: sequential fetch into a circular buffer,
// three head bytes presented to the decoder, flush-and-restart on redirect.
module inst_prefetch_queue #(
    parameter int                DEPTH    = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    inst_prefetch_queue_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]        state_q,    state_d;
    logic [PTR_W-1:0]  head_q,     head_d;
    logic [PTR_W-1:0]  tail_q,     tail_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] q_pc_q,     q_pc_d;
    logic              mem_req_q,  mem_req_d;
    logic              err_q,      err_d;
    logic [7:0]        byte_q [3];
    logic [7:0]        byte_d [3];
    logic [7:0]        queue_q [DEPTH];

    logic              wr_en_s;
    logic              legal_s;
    logic [CNT_W-1:0]  len_s;
    logic [PTR_W-1:0]  rd_idx_s [3];

    // Next-state: redirect overrides everything, otherwise fill and retire in parallel.
    always_comb begin
        len_s      = CNT_W'(bus.consume_len);
        wr_en_s    = (state_q == ST_FETCH) && mem_req_q && bus.mem_ack && !bus.redirect;
        legal_s    = bus.consume && (bus.consume_len != 2'd0) && (len_s <= count_q);
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        q_pc_d     = q_pc_q;
        err_d      = 1'b0;
        if (bus.redirect) begin
            state_d    = ST_FLUSH;
            head_d     = {PTR_W{1'b0}};
            tail_d     = {PTR_W{1'b0}};
            count_d    = {CNT_W{1'b0}};
            fetch_pc_d = bus.redirect_pc;
            q_pc_d     = bus.redirect_pc;
        end else begin
            case (state_q)
                ST_FETCH: state_d = ST_FETCH;
                ST_FLUSH: state_d = ST_FETCH;
                default:  state_d = ST_FETCH;
            endcase
            if (wr_en_s) begin
                tail_d     = tail_q + {{(PTR_W-1){1'b0}}, 1'b1};
                fetch_pc_d = fetch_pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                tail_d     = tail_q;
                fetch_pc_d = fetch_pc_q;
            end
            if (legal_s) begin
                head_d = head_q + PTR_W'(bus.consume_len);
                q_pc_d = q_pc_q + ADDR_W'(bus.consume_len);
            end else begin
                err_d  = bus.consume && (bus.consume_len != 2'd0);
            end
            count_d = count_q + CNT_W'(wr_en_s) - (legal_s ? len_s : {CNT_W{1'b0}});
        end
        mem_req_d = !bus.redirect && (count_d < FULL);
    end

    // Head-window bytes for the next cycle; a byte written this cycle bypasses the array.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rd_idx_s[k] = head_d + PTR_W'(k);
            if (CNT_W'(k) < count_d) begin
                if (wr_en_s && (rd_idx_s[k] == tail_q)) begin
                    byte_d[k] = bus.mem_rdata;
                end else begin
                    byte_d[k] = queue_q[rd_idx_s[k]];
                end
            end else begin
                byte_d[k] = 8'h00;
            end
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            head_q     <= {PTR_W{1'b0}};
            tail_q     <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            fetch_pc_q <= RESET_PC;
            q_pc_q     <= RESET_PC;
            mem_req_q  <= 1'b0;
            err_q      <= 1'b0;
            for (int k = 0; k < 3; k++) byte_q[k] <= 8'h00;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            q_pc_q     <= q_pc_d;
            mem_req_q  <= mem_req_d;
            err_q      <= err_d;
            for (int k = 0; k < 3; k++) byte_q[k] <= byte_d[k];
        end
    end

    // Byte storage; contents beyond q_count are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_s) begin
            queue_q[tail_q] <= bus.mem_rdata;
        end else begin
            queue_q[tail_q] <= queue_q[tail_q];
        end
    end

    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = fetch_pc_q;
    assign bus.q_count      = count_q;
    assign bus.q_byte0      = byte_q[0];
    assign bus.q_byte1      = byte_q[1];
    assign bus.q_byte2      = byte_q[2];
    assign bus.q_pc         = q_pc_q;
    assign bus.protocol_err = err_q;
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed self-checking bench for inst_prefetch_queue (DEPTH=16, RESET_PC=0200).
module tb_inst_prefetch_queue;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    inst_prefetch_queue_if #(.ADDR_W(16), .CNT_W(5)) bus_if ();

    inst_prefetch_queue #(
        .DEPTH    (16),
        .ADDR_W   (16),
        .RESET_PC (16'h0200)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic [7:0] rdata,
                         input logic cons, input logic [1:0] len);
        bus_if.mem_ack     = ack;
        bus_if.mem_rdata   = rdata;
        bus_if.consume     = cons;
        bus_if.consume_len = len;
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] b2);
        check_value({tag, "_b0"}, 32'(bus_if.q_byte0), 32'(b0));
        check_value({tag, "_b1"}, 32'(bus_if.q_byte1), 32'(b1));
        check_value({tag, "_b2"}, 32'(bus_if.q_byte2), 32'(b2));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus_if.redirect    = 1'b0;
        bus_if.redirect_pc = 16'h0000;
        drive(1'b0, 8'h00, 1'b0, 2'd0);
        tick();
        tick();
        check_value("rst_count", 32'(bus_if.q_count), 32'd0);
        check_value("rst_req",   32'(bus_if.mem_req), 32'd0);
        check_value("rst_addr",  32'(bus_if.mem_addr), 32'h0200);
        check_value("rst_qpc",   32'(bus_if.q_pc), 32'h0200);
        check_value("rst_err",   32'(bus_if.protocol_err), 32'd0);
        check_bytes("rst", 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        tick();
        check_value("start_req", 32'(bus_if.mem_req), 32'd1);

        // T1: three acks
        drive(1'b1, 8'hA9, 1'b0, 2'd0); tick();
        check_value("t1_fill1_count", 32'(bus_if.q_count), 32'd1);
        check_bytes("t1_fill1", 8'hA9, 8'h00, 8'h00);
        drive(1'b1, 8'h05, 1'b0, 2'd0); tick();
        drive(1'b1, 8'h8D, 1'b0, 2'd0); tick();
        check_value("t1_count", 32'(bus_if.q_count), 32'd3);
        check_bytes("t1", 8'hA9, 8'h05, 8'h8D);
        check_value("t1_qpc",  32'(bus_if.q_pc), 32'h0200);
        check_value("t1_addr", 32'(bus_if.mem_addr), 32'h0203);

        // T2: fill to saturation, then an extra ack must be ignored
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b0, 2'd0);
            tick();
        end
        check_value("t2_count", 32'(bus_if.q_count), 32'd16);
        check_value("t2_req",   32'(bus_if.mem_req), 32'd0);
        drive(1'b1, 8'hEE, 1'b0, 2'd0); tick();
        check_value("t2_count_hold", 32'(bus_if.q_count), 32'd16);
        check_value("t2_addr",  32'(bus_if.mem_addr), 32'h0210);
        check_value("t2_req_hold", 32'(bus_if.mem_req), 32'd0);

        // T3: consume 3 from full
        drive(1'b0, 8'h00, 1'b1, 2'd3); tick();
        check_value("t3_count", 32'(bus_if.q_count), 32'd13);
        check_value("t3_qpc",   32'(bus_if.q_pc), 32'h0203);
        check_value("t3_req",   32'(bus_if.mem_req), 32'd1);
        check_bytes("t3", 8'h10, 8'h11, 8'h12);
        // refill across tail wrap, then walk head to entry 15
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'hE0 + i), 1'b0, 2'd0);
            tick();
        end
        check_value("t3_refill", 32'(bus_if.q_count), 32'd16);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 2'd3);
            tick();
        end
        check_value("t3_wrap_count", 32'(bus_if.q_count), 32'd4);
        check_value("t3_wrap_qpc",   32'(bus_if.q_pc), 32'h020F);
        check_bytes("t3_wrap", 8'h1C, 8'hE0, 8'hE1);

        // T4: illegal consume
        drive(1'b0, 8'h00, 1'b1, 2'd2); tick();
        check_value("t4_count", 32'(bus_if.q_count), 32'd2);
        check_bytes("t4", 8'hE1, 8'hE2, 8'h00);
        drive(1'b0, 8'h00, 1'b1, 2'd3); tick();
        check_value("t4_err",       32'(bus_if.protocol_err), 32'd1);
        check_value("t4_count_keep", 32'(bus_if.q_count), 32'd2);
        check_value("t4_qpc_keep",   32'(bus_if.q_pc), 32'h0211);
        drive(1'b0, 8'h00, 1'b0, 2'd0); tick();
        check_value("t4_err_pulse", 32'(bus_if.protocol_err), 32'd0);

        // T5: redirect with same-cycle ack and consume
        bus_if.redirect = 1'b1; bus_if.redirect_pc = 16'hC000;
        drive(1'b1, 8'h77, 1'b1, 2'd1); tick();
        bus_if.redirect = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 2'd0);
        check_value("t5_count", 32'(bus_if.q_count), 32'd0);
        check_value("t5_req",   32'(bus_if.mem_req), 32'd0);
        check_value("t5_qpc",   32'(bus_if.q_pc), 32'hC000);
        check_value("t5_err",   32'(bus_if.protocol_err), 32'd0);
        check_bytes("t5", 8'h00, 8'h00, 8'h00);
        tick();
        check_value("t5_req_back", 32'(bus_if.mem_req), 32'd1);
        check_value("t5_addr",     32'(bus_if.mem_addr), 32'hC000);
        drive(1'b1, 8'h42, 1'b0, 2'd0); tick();
        check_value("t5_first_count", 32'(bus_if.q_count), 32'd1);
        check_value("t5_first_byte",  32'(bus_if.q_byte0), 32'h42);
        check_value("t5_first_qpc",   32'(bus_if.q_pc), 32'hC000);

        // redirect while flushing reloads the PC and extends the flush
        bus_if.redirect = 1'b1; bus_if.redirect_pc = 16'h1234;
        drive(1'b0, 8'h00, 1'b0, 2'd0); tick();
        bus_if.redirect_pc = 16'h5678; tick();
        bus_if.redirect = 1'b0;
        check_value("flush2_req", 32'(bus_if.mem_req), 32'd0);
        check_value("flush2_qpc", 32'(bus_if.q_pc), 32'h5678);
        tick();
        check_value("flush2_addr", 32'(bus_if.mem_addr), 32'h5678);
        check_value("flush2_req_back", 32'(bus_if.mem_req), 32'd1);

        // T6: fetch PC wrap
        bus_if.redirect = 1'b1; bus_if.redirect_pc = 16'hFFFF; tick();
        bus_if.redirect = 1'b0; tick();
        check_value("t6_addr", 32'(bus_if.mem_addr), 32'hFFFF);
        drive(1'b1, 8'h11, 1'b0, 2'd0); tick();
        check_value("t6_addr_wrap", 32'(bus_if.mem_addr), 32'h0000);
        check_value("t6_qpc",       32'(bus_if.q_pc), 32'hFFFF);
        drive(1'b1, 8'h22, 1'b0, 2'd0); tick();
        check_value("t6_count", 32'(bus_if.q_count), 32'd2);
        drive(1'b0, 8'h00, 1'b1, 2'd1); tick();
        check_value("t6_qpc_wrap", 32'(bus_if.q_pc), 32'h0000);
        check_value("t6_byte",     32'(bus_if.q_byte0), 32'h22);
        drive(1'b1, 8'h33, 1'b1, 2'd1); tick();
        check_value("t6_ackcons_count", 32'(bus_if.q_count), 32'd1);
        check_value("t6_ackcons_byte",  32'(bus_if.q_byte0), 32'h33);
        check_value("t6_ackcons_qpc",   32'(bus_if.q_pc), 32'h0001);
        drive(1'b0, 8'h00, 1'b0, 2'd0); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
